uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo_byte_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
    localparam int UART_FIFO_DEPTH   = 4;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-strobe input and serial/status outputs of the UART transmit stage.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = uart_pkg::UART_FIFO_DEPTH
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                                txen;
    logic [uart_pkg::UART_DATA_BITS-1:0] txpcdata;
    logic                                tx;
    logic                                busy;
    logic                                tx_done;
    logic                                ovf;
    logic [LW-1:0]                       level;

    // Upstream serializer side
    modport master (
        output txen, txpcdata,
        input  tx, busy, tx_done, ovf, level
    );

    // Transmitter side
    modport slave (
        input  txen, txpcdata,
        output tx, busy, tx_done, ovf, level
    );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Small synchronous FIFO with a combinational read port. A push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_push_ok && !rst)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. Consecutive queued bytes are sent
// as contiguous frames: the pop for the next byte happens in the last stop
// bit cycle, so its start bit begins on the very next edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    uart_state_t                r_state, w_state_nxt;
    logic [CW-1:0]              r_cnt, w_cnt_nxt;
    logic [2:0]                 r_idx, w_idx_nxt;
    logic [UART_DATA_BITS-1:0]  r_shift, w_shift_nxt;
    logic                       r_tx, w_tx_nxt;
    logic                       r_done, w_done_nxt;
    logic                       r_ovf;

    logic                       w_pop;
    logic                       w_bit_end;
    logic [UART_DATA_BITS-1:0]  w_fifo_data;
    logic                       w_full;
    logic                       w_empty;
    logic [LW-1:0]              w_level;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.txen),
        .i_data  (bus.txpcdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign w_bit_end = (r_cnt == LAST_CNT);

    // Next-state, baud/bit counters, shift register and line value
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                w_tx_nxt = 1'b1;
                // Registered pulse lands in the final stop-bit cycle
                if (r_cnt == PRE_LAST)
                    w_done_nxt = 1'b1;
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_data;
                        w_idx_nxt   = '0;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Sticky overflow: a strobe was dropped because the FIFO was full
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (bus.txen && w_full && !w_pop)
            r_ovf <= 1'b1;
    end

    assign bus.tx      = r_tx;
    assign bus.tx_done = r_done;
    assign bus.ovf     = r_ovf;
    assign bus.level   = w_level;
    assign bus.busy    = (r_state != IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a frame-decoding scoreboard monitor.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.txen     = 1'b1;
        bus.txpcdata = b;
        tick();
        bus.txen     = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < bound) begin
            tick();
            k++;
        end
        check(nm, bus.busy, 0);
    endtask

    // Count tx_done pulses
    always @(negedge clk)
        if (bus.tx_done === 1'b1) done_cnt++;

    // Decode frames mid-bit and compare against the expected byte queue
    logic [7:0] m_data;
    logic       m_stop;
    logic       m_abort;
    always begin : mon
        @(negedge clk);
        if (rst === 1'b0 && bus.tx === 1'b0) begin
            m_abort = 1'b0;
            m_stop  = 1'b0;
            m_data  = '0;
            for (int c = 1; c <= 76; c++) begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    m_abort = 1'b1;
                    break;
                end
                if (c >= 12 && c <= 68 && ((c - 12) % 8) == 0)
                    m_data[(c - 12) / 8] = bus.tx;
                if (c == 76)
                    m_stop = bus.tx;
            end
            if (!m_abort) begin
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", {23'd0, m_stop, m_data}, 32'hFFFF_FFFF);
                end else begin
                    check("frame_byte", {23'd0, m_stop, m_data}, {23'd0, 1'b1, exp_q[0]});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [9:0]  pat;
        logic [7:0]  b2b [4];
        logic [31:0] words [8];
        int d0, bad, first_done, busy_fall, ndone, peak, t_first, hi;
        logic tx1, ovfsticky;
        logic [31:0] lvl1;

        bus.txen     = 1'b0;
        bus.txpcdata = '0;

        // ---- reset ----
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.level, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_done", bus.tx_done, 0);
        d0 = done_cnt;
        hi = 1;
        repeat (100) begin
            tick();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) hi = 0;
        end
        check("rst_quiet", hi, 1);
        check("rst_no_done", done_cnt - d0, 0);

        // ---- single byte 0xA5 ----
        pat = 10'b1101001010;  // start, A5 LSB first, stop
        exp_q.push_back(8'hA5);
        strobe(8'hA5);
        check("single_level_push", bus.level, 1);
        check("single_tx_idle", bus.tx, 1);
        bad = 0; first_done = 0; busy_fall = 0; ndone = 0; tx1 = 1'b1; lvl1 = '1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 1) begin
                tx1  = bus.tx;
                lvl1 = 32'(bus.level);
            end
            if (k <= 80 && bus.tx !== pat[(k - 1) / 8]) bad++;
            if (bus.tx_done === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
            if (bus.busy === 1'b0 && busy_fall == 0) busy_fall = k;
        end
        check("single_tx_fall", tx1, 0);
        check("single_level_pop", lvl1, 0);
        check("single_bitseq_errs", bad, 0);
        check("single_done_cycle", first_done, 80);
        check("single_done_count", ndone, 1);
        check("single_busy_fall", busy_fall, 81);

        // ---- back-to-back ----
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C;
        d0 = done_cnt;
        peak = 0;
        t_first = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(b2b[i]);
            strobe(b2b[i]);
            if (i == 0) t_first = cyc;
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        wait_idle(400, "b2b_idle");
        check("b2b_peak_level", peak, 3);
        check("b2b_total_cycles", cyc - t_first, 321);
        check("b2b_done_count", done_cnt - d0, 4);
        check("b2b_drained", exp_q.size(), 0);

        // ---- overflow ----
        d0 = done_cnt;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(8'(i));
            strobe(8'(i));
            if (i == 5) check("ovf_before", bus.ovf, 0);
            if (i == 6) check("ovf_set", bus.ovf, 1);
        end
        check("ovf_level_full", bus.level, 4);
        wait_idle(600, "ovf_idle");
        ovfsticky = 1'b1;
        repeat (20) begin
            tick();
            if (bus.ovf !== 1'b1) ovfsticky = 1'b0;
        end
        check("ovf_sticky", ovfsticky, 1);
        check("ovf_done_count", done_cnt - d0, 5);
        check("ovf_drained", exp_q.size(), 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("ovf_cleared", bus.ovf, 0);

        // ---- mid-frame reset ----
        strobe(8'h81);
        strobe(8'h42);
        check("mid_level_queued", bus.level, 1);
        repeat (34) tick();           // now inside bit 3 of 0x81
        check("mid_in_bit3", bus.tx, 0);
        rst          = 1'b1;
        bus.txen     = 1'b1;          // strobe during reset must be ignored
        bus.txpcdata = 8'h99;
        tick();
        bus.txen = 1'b0;
        check("mid_tx_high", bus.tx, 1);
        check("mid_level_flushed", bus.level, 0);
        check("mid_busy", bus.busy, 0);
        rst = 1'b0;
        d0 = done_cnt;
        hi = 1;
        repeat (200) begin
            tick();
            if (bus.tx !== 1'b1) hi = 0;
        end
        check("mid_line_quiet", hi, 1);
        check("mid_no_done", done_cnt - d0, 0);

        // ---- upstream cadence (scaled spacing, > 10 bit times) ----
        words[0] = 32'hDEADBEEF; words[1] = 32'h01234567;
        words[2] = 32'h89ABCDEF; words[3] = 32'hCAFEF00D;
        words[4] = 32'h0F1E2D3C; words[5] = 32'hA55A5AA5;
        words[6] = 32'h80000001; words[7] = 32'h7E7E0000;
        d0 = done_cnt;
        peak = 0;
        hi = 1;
        for (int w = 0; w < 8; w++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(words[w][8*b +: 8]);
                strobe(words[w][8*b +: 8]);
                for (int s = 0; s < 114; s++) begin
                    if (int'(bus.level) > peak) peak = int'(bus.level);
                    if (bus.ovf !== 1'b0) hi = 0;
                    tick();
                end
            end
        end
        wait_idle(200, "cad_idle");
        check("cad_peak_level", peak, 1);
        check("cad_no_ovf", hi, 1);
        check("cad_done_count", done_cnt - d0, 32);
        check("cad_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
